counter_bank: RTL and testbench

Parametrised bank of independent up/down event counters, successor to the single 8-bit counter. Each channel has increment/decrement strobes, a direct load port, wrap or saturate mode, a terminal-count pulse and sticky overflow/underflow flags. A registered read port lets control logic sample any channel by index. All channel values are also exported flat, for monitoring and for the SSID sequencing logic.

---
 rtl/counter_bank.sv | 90 +++++++++
 tb/tb_counter_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// Bank of independent up/down event counters with wrap/saturate mode, terminal-count
// pulses, sticky overflow/underflow flags and a registered indexed read port.
module counter_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned CH_BITS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic                      load_valid,
    input  logic [CH_BITS-1:0]        load_ch,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      rd_req,
    input  logic [CH_BITS-1:0]        rd_ch,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS*WIDTH-1:0] count_flat,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       unf,
    input  logic [CHANNELS-1:0]       flag_clr
);

    localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};

    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]            tc_q, ovf_q, unf_q;
    logic [CHANNELS-1:0]            ovf_ev, unf_ev;
    logic                           rd_valid_q;
    logic [WIDTH-1:0]               rd_data_q, rd_mux;

    always_comb begin
        count_d = count_q;
        ovf_ev  = '0;
        unf_ev  = '0;
        rd_mux  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (load_valid && load_ch == CH_BITS'(i)) begin
                count_d[i] = load_value;
            end else if (enable && inc[i] && !dec[i]) begin
                if (count_q[i] == MaxCount) begin
                    ovf_ev[i] = 1'b1;
                    if (SATURATE == 0) count_d[i] = '0;
                end else begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                end
            end else if (enable && dec[i] && !inc[i]) begin
                if (count_q[i] == '0) begin
                    unf_ev[i] = 1'b1;
                    if (SATURATE == 0) count_d[i] = MaxCount;
                end else begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end
            // Out-of-range indices match no channel and read back as zero.
            if (rd_ch == CH_BITS'(i)) rd_mux = count_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            tc_q       <= '0;
            ovf_q      <= '0;
            unf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            tc_q       <= ovf_ev | unf_ev;
            // A new boundary event outranks a clear in the same cycle.
            ovf_q      <= ovf_ev | (ovf_q & ~flag_clr);
            unf_q      <= unf_ev | (unf_q & ~flag_clr);
            rd_valid_q <= rd_req;
            if (rd_req) rd_data_q <= rd_mux;
        end
    end

    assign count_flat = count_q;
    assign tc         = tc_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: one wrap-mode and one saturate-mode instance share stimulus.
module tb_counter_bank;

    logic        clk = 1'b0;
    logic        reset, enable, load_valid, rd_req;
    logic [3:0]  inc, dec, flag_clr;
    logic [2:0]  load_ch, rd_ch;
    logic [7:0]  load_value;

    logic        rd_valid_w, rd_valid_s;
    logic [7:0]  rd_data_w, rd_data_s;
    logic [31:0] count_w, count_s;
    logic [3:0]  tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0), .CH_BITS(3)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .inc(inc), .dec(dec),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid_w), .rd_data(rd_data_w),
        .count_flat(count_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w), .flag_clr(flag_clr)
    );

    counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1), .CH_BITS(3)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .inc(inc), .dec(dec),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
        .count_flat(count_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s), .flag_clr(flag_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; enable = 1'b0; load_valid = 1'b0; rd_req = 1'b0;
        inc = '0; dec = '0; flag_clr = '0; load_ch = '0; rd_ch = '0; load_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input logic [2:0] ch, input logic [7:0] val);
        load_valid = 1'b1; load_ch = ch; load_value = val;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        enable = 1'b1; inc = 4'hF; load_valid = 1'b1; load_ch = 3'd1; load_value = 8'h5A;
        rd_req = 1'b1; rd_ch = 3'd1; reset = 1'b1;
        step();
        idle_inputs();
        checks++; if (count_w !== 32'h0) begin errors++;
            $display("FAIL reset_count: got %h expected %h", count_w, 32'h0); end
        checks++; if ({tc_w, ovf_w, unf_w} !== 12'h0) begin errors++;
            $display("FAIL reset_flags: got %h expected %h", {tc_w, ovf_w, unf_w}, 12'h0); end
        checks++; if ({rd_valid_w, rd_data_w} !== 9'h0) begin errors++;
            $display("FAIL reset_read: got %h expected %h", {rd_valid_w, rd_data_w}, 9'h0); end
        checks++; if (count_s !== 32'h0) begin errors++;
            $display("FAIL reset_count_sat: got %h expected %h", count_s, 32'h0); end
    endtask

    task automatic test_inc();
        do_reset();
        enable = 1'b1; inc = 4'b0001;
        repeat (5) step();
        idle_inputs();
        checks++; if (count_w !== 32'h0000_0005) begin errors++;
            $display("FAIL inc_five: got %h expected %h", count_w, 32'h5); end
        checks++; if (tc_w !== 4'h0) begin errors++;
            $display("FAIL inc_tc: got %h expected %h", tc_w, 4'h0); end
    endtask

    task automatic test_wrap();
        do_reset();
        load(3'd1, 8'hFE);
        enable = 1'b1; inc = 4'b0010;
        step();
        checks++; if (count_w[15:8] !== 8'hFF || tc_w !== 4'h0) begin errors++;
            $display("FAIL wrap_ff: got cnt=%h tc=%h expected cnt=ff tc=0", count_w[15:8], tc_w); end
        step();
        idle_inputs();
        checks++; if (count_w[15:8] !== 8'h00) begin errors++;
            $display("FAIL wrap_zero: got %h expected %h", count_w[15:8], 8'h00); end
        checks++; if (tc_w !== 4'b0010 || ovf_w !== 4'b0010) begin errors++;
            $display("FAIL wrap_tc_ovf: got tc=%h ovf=%h expected tc=2 ovf=2", tc_w, ovf_w); end
        step();
        checks++; if (tc_w !== 4'h0 || ovf_w !== 4'b0010) begin errors++;
            $display("FAIL wrap_sticky: got tc=%h ovf=%h expected tc=0 ovf=2", tc_w, ovf_w); end
        flag_clr = 4'b0010;
        step();
        flag_clr = '0;
        checks++; if (ovf_w !== 4'h0) begin errors++;
            $display("FAIL wrap_clr: got %h expected %h", ovf_w, 4'h0); end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1'b1; dec = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (count_s[23:16] !== 8'h00 || tc_s !== 4'b0100 || unf_s !== 4'b0100)
            begin errors++;
                $display("FAIL sat_dec%0d: got cnt=%h tc=%h unf=%h expected cnt=00 tc=4 unf=4",
                         k, count_s[23:16], tc_s, unf_s);
            end
        end
        checks++; if (count_w[23:16] !== 8'hFD || unf_w !== 4'b0100) begin errors++;
            $display("FAIL wrap_dec: got cnt=%h unf=%h expected cnt=fd unf=4",
                     count_w[23:16], unf_w); end
        idle_inputs();
        load(3'd2, 8'h33);
        enable = 1'b1; inc = 4'b0100; dec = 4'b0100;
        repeat (2) step();
        idle_inputs();
        checks++; if (count_s[23:16] !== 8'h33 || tc_s !== 4'h0) begin errors++;
            $display("FAIL sat_incdec: got cnt=%h tc=%h expected cnt=33 tc=0",
                     count_s[23:16], tc_s); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(3'd3, 8'h07);
        load_valid = 1'b1; load_ch = 3'd3; load_value = 8'h40;
        enable = 1'b1; inc = 4'b1000; rd_req = 1'b1; rd_ch = 3'd3;
        step();
        load_valid = 1'b0; inc = '0;
        checks++; if (rd_valid_w !== 1'b1 || rd_data_w !== 8'h07) begin errors++;
            $display("FAIL rd_preupdate: got v=%b d=%h expected v=1 d=07", rd_valid_w, rd_data_w); end
        checks++; if (count_w !== 32'h4000_0000 || tc_w !== 4'h0) begin errors++;
            $display("FAIL rd_load_wins: got cnt=%h tc=%h expected cnt=40000000 tc=0",
                     count_w, tc_w); end
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid_w !== 1'b1 || rd_data_w !== 8'h40) begin errors++;
            $display("FAIL rd_b2b: got v=%b d=%h expected v=1 d=40", rd_valid_w, rd_data_w); end
        step();
        checks++; if (rd_valid_w !== 1'b0 || rd_data_w !== 8'h40) begin errors++;
            $display("FAIL rd_hold: got v=%b d=%h expected v=0 d=40", rd_valid_w, rd_data_w); end
        rd_req = 1'b1; rd_ch = 3'd5;
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid_w !== 1'b1 || rd_data_w !== 8'h00) begin errors++;
            $display("FAIL rd_oob: got v=%b d=%h expected v=1 d=00", rd_valid_w, rd_data_w); end
        load(3'd5, 8'hAA);
        checks++; if (count_w !== 32'h4000_0000) begin errors++;
            $display("FAIL load_oob: got %h expected %h", count_w, 32'h4000_0000); end
        idle_inputs();
    endtask

    task automatic test_enable_gate();
        do_reset();
        load(3'd0, 8'h11); load(3'd1, 8'h22); load(3'd2, 8'h33); load(3'd3, 8'h44);
        enable = 1'b0; inc = 4'hF;
        repeat (4) step();
        checks++; if (count_w !== 32'h4433_2211) begin errors++;
            $display("FAIL gate_hold: got %h expected %h", count_w, 32'h44332211); end
        load(3'd1, 8'h99);
        checks++; if (count_w !== 32'h4433_9911) begin errors++;
            $display("FAIL gate_load: got %h expected %h", count_w, 32'h44339911); end
        idle_inputs();
        load(3'd0, 8'hFF);
        enable = 1'b1; inc = 4'b0001;
        step();
        checks++; if (ovf_w !== 4'b0001 || tc_w !== 4'b0001) begin errors++;
            $display("FAIL gate_preovf: got ovf=%h tc=%h expected ovf=1 tc=1", ovf_w, tc_w); end
        load_valid = 1'b1; load_ch = 3'd2; load_value = 8'h55; rd_req = 1'b1; rd_ch = 3'd1;
        reset = 1'b1;
        step();
        idle_inputs();
        checks++; if (count_w !== 32'h0 || {tc_w, ovf_w, unf_w} !== 12'h0 || rd_valid_w !== 1'b0)
        begin errors++;
            $display("FAIL mid_reset: got cnt=%h flags=%h v=%b expected all zero",
                     count_w, {tc_w, ovf_w, unf_w}, rd_valid_w);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        load(3'd0, 8'hFF);
        enable = 1'b1; inc = 4'b0001;
        step();
        idle_inputs();
        load(3'd0, 8'hFF);
        enable = 1'b1; inc = 4'b0001; flag_clr = 4'b0001;
        step();
        idle_inputs();
        checks++; if (ovf_w !== 4'b0001 || count_w[7:0] !== 8'h00) begin errors++;
            $display("FAIL set_wins_wrap: got ovf=%h cnt=%h expected ovf=1 cnt=00",
                     ovf_w, count_w[7:0]); end
        checks++; if (ovf_s !== 4'b0001 || count_s[7:0] !== 8'hFF) begin errors++;
            $display("FAIL set_wins_sat: got ovf=%h cnt=%h expected ovf=1 cnt=ff",
                     ovf_s, count_s[7:0]); end
        flag_clr = 4'b0001;
        step();
        flag_clr = '0;
        checks++; if (ovf_s !== 4'h0) begin errors++;
            $display("FAIL set_then_clr: got %h expected %h", ovf_s, 4'h0); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_inc();
        test_wrap();
        test_saturate();
        test_back_to_back();
        test_enable_gate();
        test_set_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
